// File: rtl/wb_pkg.sv
// Shared types for the Wishbone burst slave: cycle type codes, FSM states, read-data source.
package wb_pkg;

    typedef enum logic [2:0] {
        CTI_CLASSIC = 3'b000,
        CTI_CONST   = 3'b001,
        CTI_INCR    = 3'b010,
        CTI_END     = 3'b111
    } cti_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLASSIC,
        ST_RECOVER,
        ST_BURST
    } state_t;

    typedef enum logic [1:0] {
        RD_ZERO,
        RD_MEM,
        RD_TAG
    } rd_src_t;

    localparam logic [15:0] WR_COUNT_MAX = 16'hFFFF;

    function automatic logic is_burst_cti(input logic [2:0] cti);
        return (cti == CTI_CONST) || (cti == CTI_INCR);
    endfunction

endpackage

// File: rtl/wb_slave_mem.sv
// Byte-lane writable word memory with a registered read port (maps onto block RAM).
module wb_slave_mem #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 12
) (
    input  logic                    clk_i,
    input  logic                    we_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [ADDR_WIDTH-1:0]   waddr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [ADDR_WIDTH-1:0]   raddr_i,
    output logic [DATA_WIDTH-1:0]   rdata_o
);
    localparam int SEL_WIDTH = DATA_WIDTH / 8;

    logic [SEL_WIDTH-1:0][7:0] mem_q [DEPTH];
    logic [SEL_WIDTH-1:0][7:0] rdata_q;
    logic [SEL_WIDTH-1:0]      lane_we;

    for (genvar gi = 0; gi < SEL_WIDTH; gi++) begin : g_lane
        assign lane_we[gi] = we_i & be_i[gi];
    end

    always_ff @(posedge clk_i) begin
        for (int k = 0; k < SEL_WIDTH; k++) begin
            if (lane_we[k]) begin
                mem_q[waddr_i][k] <= wdata_i[k*8 +: 8];
            end
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/wb_burst_slave.sv
// Wishbone B4 registered-feedback slave: classic, constant and incrementing bursts plus a tag-space write counter.
// Define WB_SLAVE_ERR_EN to answer out-of-range memory beats with err_o instead of ack_o.
module wb_burst_slave
    import wb_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 12
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    cyc_i,
    input  logic                    stb_i,
    input  logic                    we_i,
    input  logic [ADDR_WIDTH-1:0]   adr_i,
    input  logic [DATA_WIDTH-1:0]   dat_i,
    input  logic [DATA_WIDTH/8-1:0] sel_i,
    input  logic [2:0]              cti_i,
    input  logic                    tga_i,
    output logic [DATA_WIDTH-1:0]   dat_o,
    output logic                    ack_o,
    output logic                    err_o
);
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(DEPTH);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    tag_q, tag_d;
    rd_src_t                 rd_src_q, rd_src_d;
    logic [15:0]             wr_count_q, wr_count_d;
    logic                    bus_req, active, beat, addr_ok;
    logic                    ack, err, mem_we, tag_clr;
    logic [DATA_WIDTH-1:0]   mem_rdata;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return {1'b0, a} < DEPTH_LIM;
    endfunction

    assign bus_req = cyc_i & stb_i;
    assign active  = (state_q == ST_CLASSIC) || (state_q == ST_BURST);
    assign beat    = bus_req & active;
    assign addr_ok = in_range(addr_q);

`ifdef WB_SLAVE_ERR_EN
    assign ack = beat & (tag_q | addr_ok);
    assign err = beat & ~tag_q & ~addr_ok;
`else
    assign ack = beat;
    assign err = 1'b0;
`endif

    // sel_i=0 is acknowledged but is not a write, so it does not count either
    assign mem_we  = ack & we_i & ~tag_q & addr_ok & (|sel_i);
    assign tag_clr = ack & we_i & tag_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        tag_d   = tag_q;
        case (state_q)
            ST_IDLE: begin
                if (bus_req) begin
                    addr_d  = adr_i;
                    tag_d   = tga_i;
                    state_d = is_burst_cti(cti_i) ? ST_BURST : ST_CLASSIC;
                end
            end
            ST_CLASSIC: state_d = ST_RECOVER;
            ST_RECOVER: state_d = ST_IDLE;
            ST_BURST: begin
                if (err) begin
                    state_d = ST_IDLE;
                end else if (ack) begin
                    if (cti_i == CTI_END) begin
                        state_d = ST_IDLE;
                    end else if (cti_i == CTI_INCR) begin
                        addr_d = addr_q + ADDR_WIDTH'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (!cyc_i) begin
            state_d = ST_IDLE;
        end
    end

    // Read source is chosen one edge ahead so the data lines up with the ack cycle
    always_comb begin
        rd_src_d = RD_ZERO;
        if (tag_d) begin
            rd_src_d = RD_TAG;
        end else if (in_range(addr_d)) begin
            rd_src_d = RD_MEM;
        end
    end

    always_comb begin
        wr_count_d = wr_count_q;
        if (tag_clr) begin
            wr_count_d = '0;
        end else if (mem_we && (wr_count_q != WR_COUNT_MAX)) begin
            wr_count_d = wr_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            tag_q      <= 1'b0;
            rd_src_q   <= RD_ZERO;
            wr_count_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            tag_q      <= tag_d;
            rd_src_q   <= rd_src_d;
            wr_count_q <= wr_count_d;
        end
    end

    wb_slave_mem #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH)
    ) u_mem (
        .clk_i  (clk_i),
        .we_i   (mem_we),
        .be_i   (sel_i),
        .waddr_i(addr_q),
        .wdata_i(dat_i),
        .raddr_i(addr_d),
        .rdata_o(mem_rdata)
    );

    always_comb begin
        case (rd_src_q)
            RD_MEM:  dat_o = mem_rdata;
            RD_TAG:  dat_o = DATA_WIDTH'(wr_count_q);
            default: dat_o = '0;
        endcase
    end

    assign ack_o = ack;
    assign err_o = err;

endmodule

// File: tb/tb_wb_burst_slave.sv
// Bench for wb_burst_slave: classic table vectors, burst scoreboard, abort and reset sequences.
module tb_wb_burst_slave;
    import wb_pkg::*;

`ifdef WB_SLAVE_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_i, cyc, stb, we, tga;
    logic [3:0]  adr, sel;
    logic [31:0] dat, dat_o;
    logic [2:0]  cti;
    logic        ack_o, err_o;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    wb_burst_slave #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .DEPTH(12)) dut (
        .clk_i(clk), .rst_i(rst_i), .cyc_i(cyc), .stb_i(stb), .we_i(we),
        .adr_i(adr), .dat_i(dat), .sel_i(sel), .cti_i(cti), .tga_i(tga),
        .dat_o(dat_o), .ack_o(ack_o), .err_o(err_o)
    );

    typedef struct {
        logic        we;
        logic [3:0]  adr;
        logic        tga;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        exp_err;
        logic [31:0] exp_dat;
        string       nm;
    } vec_t;

    typedef struct {
        logic        rd;
        logic        err;
        logic [31:0] dat;
        string       nm;
    } sb_t;

    sb_t         sb[$];
    logic [31:0] bdat [8];
    logic [31:0] bexp [8];
    vec_t        vec_a [11];
    vec_t        vec_b [8];

    function automatic vec_t mk(input logic w, input logic [3:0] a, input logic t, input logic [31:0] d,
                                input logic [3:0] s, input logic e, input logic [31:0] x, input string n);
        vec_t v;
        v.we = w; v.adr = a; v.tga = t; v.dat = d; v.sel = s; v.exp_err = e; v.exp_dat = x; v.nm = n;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end else begin
            $display("[TB] ok %s = %h", nm, act);
        end
    endtask

    task automatic idle_bus();
        cyc = 1'b0; stb = 1'b0; we = 1'b0; tga = 1'b0;
        adr = '0; dat = '0; sel = '0; cti = CTI_CLASSIC;
    endtask

    task automatic end_cycle();
        @(posedge clk); #1;
        idle_bus();
    endtask

    task automatic drive_beat(input logic w, input logic [3:0] a, input logic t, input logic [2:0] c,
                              input logic [31:0] d, input logic [3:0] s);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; tga = t; cti = c; dat = d; sel = s;
    endtask

    task automatic push_beat(input string nm, input logic rd, input logic e, input logic [31:0] d);
        sb_t s;
        s.rd = rd; s.err = e; s.dat = d; s.nm = nm;
        sb.push_back(s);
    endtask

    // Drives an n-beat access (n=1 is classic); returns at the negedge of the last ack/err cycle
    task automatic run_burst(input string nm, input logic w, input logic [3:0] a, input logic t,
                             input logic [2:0] body, input int n, input logic [3:0] s, input logic exp_err);
        int beat, first, gaps;
        logic [2:0] c;
        sb_t e;
        repeat (2) @(posedge clk);
        #1;
        beat = 0; first = -1; gaps = 0;
        c = (n == 1) ? CTI_CLASSIC : ((n == 1) ? CTI_END : body);
        drive_beat(w, a, t, c, bdat[0], s);
        push_beat($sformatf("%s_b0", nm), !w, exp_err, bexp[0]);
        for (int cy = 0; cy < 20 && beat < n; cy++) begin
            @(negedge clk);
            if (ack_o || err_o) begin
                e = sb.pop_front();
                check({e.nm, "_err"}, 32'(err_o), 32'(e.err));
                if (e.rd && !e.err) check({e.nm, "_dat"}, dat_o, e.dat);
                if (first < 0) first = cy;
                beat++;
                if (err_o) break;
                if (beat < n) begin
                    @(posedge clk); #1;
                    c = (beat == n - 1) ? CTI_END : body;
                    drive_beat(w, a, t, c, bdat[beat], s);
                    push_beat($sformatf("%s_b%0d", nm, beat), !w, exp_err, bexp[beat]);
                end
            end else begin
                if (first >= 0) gaps++;
                @(posedge clk); #1;
            end
        end
        check({nm, "_latency"}, 32'(first), 32'd1);
        check({nm, "_beats"}, 32'(beat), exp_err ? 32'd1 : 32'(n));
        if (n > 1) check({nm, "_gaps"}, 32'(gaps), 32'd0);
        if (sb.size() != 0) begin
            check({nm, "_sb_left"}, 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic apply_vec(input vec_t v);
        bdat[0] = v.dat;
        bexp[0] = v.exp_dat;
        run_burst(v.nm, v.we, v.adr, v.tga, CTI_CLASSIC, 1, v.sel, v.exp_err);
        end_cycle();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic got;
        vec_a[0]  = mk(1, 4'd0,  0, 32'h0000_1111, 4'hF, 0,      32'h0, "w0");
        vec_a[1]  = mk(0, 4'd0,  0, 32'h0,         4'hF, 0,      32'h0000_1111, "r0");
        vec_a[2]  = mk(1, 4'd7,  0, 32'h7777_7777, 4'hF, 0,      32'h0, "w7");
        vec_a[3]  = mk(1, 4'd9,  0, 32'hAAAA_BBBB, 4'hF, 0,      32'h0, "w9_full");
        vec_a[4]  = mk(1, 4'd9,  0, 32'h1111_2222, 4'h3, 0,      32'h0, "w9_lanes");
        vec_a[5]  = mk(0, 4'd9,  0, 32'h0,         4'hF, 0,      32'hAAAA_2222, "r9");
        vec_a[6]  = mk(0, 4'd7,  0, 32'h0,         4'hF, 0,      32'h7777_7777, "r7");
        vec_a[7]  = mk(1, 4'd13, 0, 32'h1234_5678, 4'hF, ERR_EN, 32'h0, "w13_oor");
        vec_a[8]  = mk(0, 4'd13, 0, 32'h0,         4'hF, ERR_EN, 32'h0, "r13_oor");
        vec_a[9]  = mk(1, 4'd0,  0, 32'hFFFF_FFFF, 4'h0, 0,      32'h0, "w0_sel0");
        vec_a[10] = mk(0, 4'd0,  0, 32'h0,         4'hF, 0,      32'h0000_1111, "r0_after_sel0");

        // counted writes: w0, w7, w9 x2, incr burst x4, const burst x3 = 11
        vec_b[0] = mk(0, 4'd5,  0, 32'h0,         4'hF, 0, 32'hC000_0002, "r5_const");
        vec_b[1] = mk(0, 4'd6,  0, 32'h0,         4'hF, 0, 32'hA000_0003, "r6_kept");
        vec_b[2] = mk(0, 4'd7,  0, 32'h0,         4'hF, 0, 32'h7777_7777, "r7_kept");
        vec_b[3] = mk(0, 4'd3,  0, 32'h0,         4'hF, 0, 32'hA000_0000, "r3");
        vec_b[4] = mk(0, 4'd13, 1, 32'h0,         4'hF, 0, 32'd11,        "tag_rd_count");
        vec_b[5] = mk(1, 4'd0,  1, 32'hFFFF_FFFF, 4'hF, 0, 32'h0,         "tag_wr_clear");
        vec_b[6] = mk(0, 4'd0,  1, 32'h0,         4'hF, 0, 32'd0,         "tag_rd_zero");
        vec_b[7] = mk(0, 4'd0,  0, 32'h0,         4'hF, 0, 32'h0000_1111, "r0_after_tag_wr");

        rst_i = 1'b0;
        idle_bus();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ack", 32'(ack_o), 32'd0);
        check("reset_err", 32'(err_o), 32'd0);
        check("reset_dat", dat_o, 32'd0);
        rst_i = 1'b1;

        for (int i = 0; i < 11; i++) apply_vec(vec_a[i]);

        for (int i = 0; i < 4; i++) bdat[i] = 32'hA000_0000 + 32'(i);
        run_burst("incr_wr", 1, 4'd3, 0, CTI_INCR, 4, 4'hF, 0);
        @(posedge clk); #1;
        we = 1'b0; cti = CTI_CLASSIC;
        @(negedge clk);
        check("incr_end_idle_ack", 32'(ack_o), 32'd0);
        end_cycle();

        for (int i = 0; i < 4; i++) bexp[i] = 32'hA000_0000 + 32'(i);
        run_burst("incr_rd", 0, 4'd3, 0, CTI_INCR, 4, 4'hF, 0);
        end_cycle();

        for (int i = 0; i < 3; i++) bdat[i] = 32'hC000_0000 + 32'(i);
        run_burst("const_wr", 1, 4'd5, 0, CTI_CONST, 3, 4'hF, 0);
        end_cycle();

        for (int i = 0; i < 8; i++) apply_vec(vec_b[i]);

        // cyc_i dropped after one acked beat of an incrementing write burst
        repeat (2) @(posedge clk);
        #1;
        drive_beat(1, 4'd1, 0, CTI_INCR, 32'hB1B1_B1B1, 4'hF);
        got = 1'b0;
        for (int i = 0; i < 4 && !got; i++) begin
            @(negedge clk);
            if (ack_o) got = 1'b1;
            else begin @(posedge clk); #1; end
        end
        check("abort_first_ack", 32'(got), 32'd1);
        @(posedge clk); #1;
        cyc = 1'b0;
        @(negedge clk);
        check("abort_cyc_low_ack", 32'(ack_o), 32'd0);
        @(posedge clk); #1;
        drive_beat(0, 4'd1, 0, CTI_CLASSIC, 32'h0, 4'hF);
        @(negedge clk);
        check("abort_back_to_idle", 32'(ack_o), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("abort_rd_ack", 32'(ack_o), 32'd1);
        check("abort_rd_dat", dat_o, 32'hB1B1_B1B1);
        end_cycle();

        // reset pulled low while a burst write beat is being acknowledged
        bdat[0] = 32'h2222_0000;
        run_burst("w2_base", 1, 4'd2, 0, CTI_CLASSIC, 1, 4'hF, 0);
        end_cycle();
        repeat (2) @(posedge clk);
        #1;
        drive_beat(1, 4'd2, 0, CTI_INCR, 32'hDEAD_BEEF, 4'hF);
        @(posedge clk); #2;
        check("rst_pre_ack", 32'(ack_o), 32'd1);
        rst_i = 1'b0;
        #1;
        check("rst_async_ack", 32'(ack_o), 32'd0);
        check("rst_async_dat", dat_o, 32'd0);
        @(posedge clk); #1;
        idle_bus();
        @(negedge clk);
        rst_i = 1'b1;
        bexp[0] = 32'd0;
        run_burst("tag_after_rst", 0, 4'd0, 1, CTI_CLASSIC, 1, 4'hF, 0);
        end_cycle();
        bexp[0] = 32'h2222_0000;
        run_burst("r2_not_written", 0, 4'd2, 0, CTI_CLASSIC, 1, 4'hF, 0);
        end_cycle();

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
